cv32e40x_div_iter: RTL and testbench

Iterative radix-2 integer divider that executes the RV32M `div`, `divu`, `rem` and `remu` instructions after the M decoder has classified them. It sits in the execute stage beside the multiplier and takes `div_en` and `div_operator` plus the two register operands. It returns one 32-bit result per accepted operation through a valid/ready handshake. It is the responder to the decoder's divide requests: it consumes the decoded control and produces the architectural result.

---
 rtl/cv32e40x_div_iter_if.sv | 26 ++
 rtl/cv32e40x_div_iter.sv | 158 +++++++++++++++
 tb/tb_cv32e40x_div_iter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cv32e40x_div_iter_if.sv
// Handshake and data bundle between the M-extension decode/execute logic and the
// iterative divider.
interface cv32e40x_div_iter_if;
   logic        div_en_i;
   logic [1:0]  div_operator_i;  // 0:DIV 1:DIVU 2:REM 3:REMU
   logic [31:0] op_a_i;          // divisor (rs2)
   logic [31:0] op_b_i;          // dividend (rs1)
   logic        valid_i;
   logic        ready_o;
   logic        kill_i;
   logic [31:0] result_o;
   logic        valid_o;
   logic        ready_i;

   // Divider side
   modport slave (
      input  div_en_i, div_operator_i, op_a_i, op_b_i, valid_i, kill_i, ready_i,
      output ready_o, result_o, valid_o
   );

   // Requesting side
   modport master (
      output div_en_i, div_operator_i, op_a_i, op_b_i, valid_i, kill_i, ready_i,
      input  ready_o, result_o, valid_o
   );
endinterface

// File: rtl/cv32e40x_div_iter.sv
// Iterative radix-2 restoring divider for RV32M div/divu/rem/remu.
// One quotient bit per cycle; divide-by-zero and signed overflow resolve at accept.
module cv32e40x_div_iter #(
   parameter int unsigned DIV_CYCLES = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   cv32e40x_div_iter_if.slave         bus
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DIV    = 2'd1;
   localparam logic [1:0] S_FINISH = 2'd2;

   localparam logic [1:0] DIV_DIV  = 2'd0;
   localparam logic [1:0] DIV_REM  = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] rem_q, rem_d;       // partial remainder
   logic [31:0] dvd_q, dvd_d;       // dividend bits shift out, quotient bits shift in
   logic [31:0] dvs_q, dvs_d;       // divisor magnitude
   logic        is_rem_q, is_rem_d;
   logic        neg_quot_q, neg_quot_d;
   logic        neg_rem_q, neg_rem_d;
   logic [31:0] result_q, result_d;

   logic        ready;
   logic        accept;

   // Operand decode at accept time
   logic        in_signed, in_rem, sign_a, sign_b, div_zero, overflow;
   logic [31:0] mag_a, mag_b, special_res;

   // One restoring step
   logic [32:0] rem_shift, diff;
   logic        qbit;
   logic [31:0] rem_next, quot_next, final_res;

   assign ready  = (state_q == S_IDLE) && !rst;
   assign accept = bus.valid_i && bus.div_en_i && ready && !bus.kill_i;

   assign bus.ready_o  = ready;
   assign bus.valid_o  = (state_q == S_FINISH);
   assign bus.result_o = result_q;

   // Classify the incoming request and compute special-case results
   always_comb begin
      in_signed   = (bus.div_operator_i == DIV_DIV) || (bus.div_operator_i == DIV_REM);
      in_rem      = bus.div_operator_i[1];
      sign_a      = in_signed && bus.op_a_i[31];
      sign_b      = in_signed && bus.op_b_i[31];
      mag_a       = sign_a ? (32'd0 - bus.op_a_i) : bus.op_a_i;
      mag_b       = sign_b ? (32'd0 - bus.op_b_i) : bus.op_b_i;
      div_zero    = (bus.op_a_i == 32'd0);
      overflow    = in_signed && (bus.op_b_i == 32'h8000_0000) && (bus.op_a_i == 32'hFFFF_FFFF);
      special_res = 32'd0;
      if (div_zero) begin
         special_res = in_rem ? bus.op_b_i : 32'hFFFF_FFFF;
      end else if (overflow) begin
         special_res = in_rem ? 32'd0 : 32'h8000_0000;
      end
   end

   // Restoring step: shift in the next dividend bit, trial-subtract the divisor
   always_comb begin
      rem_shift = {rem_q, dvd_q[31]};
      diff      = rem_shift - {1'b0, dvs_q};
      // diff[32] is the borrow: the remainder is always below 2*divisor here
      qbit      = !diff[32];
      rem_next  = qbit ? diff[31:0] : rem_shift[31:0];
      quot_next = {dvd_q[30:0], qbit};
      if (is_rem_q) begin
         final_res = neg_rem_q ? (32'd0 - rem_next) : rem_next;
      end else begin
         final_res = neg_quot_q ? (32'd0 - quot_next) : quot_next;
      end
   end

   // Next-state logic for the control FSM and datapath registers
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      dvd_d      = dvd_q;
      dvs_d      = dvs_q;
      is_rem_d   = is_rem_q;
      neg_quot_d = neg_quot_q;
      neg_rem_d  = neg_rem_q;
      result_d   = result_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               is_rem_d   = in_rem;
               neg_quot_d = sign_a ^ sign_b;
               neg_rem_d  = sign_b;
               dvs_d      = mag_a;
               dvd_d      = mag_b;
               rem_d      = 32'd0;
               cnt_d      = 5'(DIV_CYCLES - 1);
               if (div_zero || overflow) begin
                  result_d = special_res;
                  state_d  = S_FINISH;
               end else begin
                  state_d  = S_DIV;
               end
            end
         end
         S_DIV: begin
            rem_d = rem_next;
            dvd_d = quot_next;
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd0) begin
               result_d = final_res;
               state_d  = S_FINISH;
            end
         end
         S_FINISH: begin
            if (bus.ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A flush abandons whatever is in flight, including an unconsumed result
      if (bus.kill_i) begin
         state_d = S_IDLE;
      end
   end

   // State registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 5'd0;
         rem_q      <= 32'd0;
         dvd_q      <= 32'd0;
         dvs_q      <= 32'd0;
         is_rem_q   <= 1'b0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         result_q   <= 32'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         dvd_q      <= dvd_d;
         dvs_q      <= dvs_d;
         is_rem_q   <= is_rem_d;
         neg_quot_q <= neg_quot_d;
         neg_rem_q  <= neg_rem_d;
         result_q   <= result_d;
      end
   end

endmodule

// File: tb/tb_cv32e40x_div_iter.sv
// Directed self-checking bench for cv32e40x_div_iter.
module tb_cv32e40x_div_iter;

   localparam logic [1:0] OP_DIV  = 2'd0;
   localparam logic [1:0] OP_DIVU = 2'd1;
   localparam logic [1:0] OP_REM  = 2'd2;
   localparam logic [1:0] OP_REMU = 2'd3;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   cv32e40x_div_iter_if bus ();

   cv32e40x_div_iter #(.DIV_CYCLES(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present a request for one edge; returns in the cycle after the accept edge
   task automatic issue(input logic [1:0] op, input logic [31:0] dvs, input logic [31:0] dvd);
      @(posedge clk); #1;
      bus.div_en_i       = 1'b1;
      bus.valid_i        = 1'b1;
      bus.div_operator_i = op;
      bus.op_a_i         = dvs;
      bus.op_b_i         = dvd;
      @(posedge clk); #1;
      bus.valid_i        = 1'b0;
      bus.div_en_i       = 1'b0;
      bus.op_a_i         = $urandom;
      bus.op_b_i         = $urandom;
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] dvs, input logic [31:0] dvd,
                         input logic [31:0] exp, input int exp_lat, input string name);
      int lat;
      issue(op, dvs, dvd);
      lat = 1;
      while (!bus.valid_o && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      n_cmp++;
      if (lat !== exp_lat) begin
         n_err++;
         $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
      end
      n_cmp++;
      if (bus.result_o !== exp) begin
         n_err++;
         $display("FAIL %s result: got %h expected %h", name, bus.result_o, exp);
      end
      n_cmp++;
      if (bus.ready_o !== 1'b0) begin
         n_err++;
         $display("FAIL %s ready_o while finished: got %b expected 0", name, bus.ready_o);
      end
      bus.ready_i = 1'b1;
      @(posedge clk); #1;
      bus.ready_i = 1'b0;
      n_cmp++;
      if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL %s after handshake: ready_o=%b valid_o=%b expected 1/0",
                  name, bus.ready_o, bus.valid_o);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (bus.ready_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.result_o !== 32'd0) begin
         n_err++;
         $display("FAIL reset outputs: ready_o=%b valid_o=%b result_o=%h expected 0/0/0",
                  bus.ready_o, bus.valid_o, bus.result_o);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL post-reset: ready_o=%b valid_o=%b expected 1/0",
                  bus.ready_o, bus.valid_o);
      end
   endtask

   task automatic test_unsigned();
      run_op(OP_DIVU, 32'd7, 32'd100, 32'd14, 33, "divu_100_7");
      run_op(OP_REMU, 32'd7, 32'd100, 32'd2, 33, "remu_100_7");
      run_op(OP_DIVU, 32'h10, 32'hFFFF_FFFF, 32'h0FFF_FFFF, 33, "divu_max_16");
      run_op(OP_REMU, 32'h10, 32'hFFFF_FFFF, 32'hF, 33, "remu_max_16");
   endtask

   task automatic test_signed();
      run_op(OP_DIV, 32'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFD, 33, "div_m7_2");
      run_op(OP_REM, 32'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 33, "rem_m7_2");
      run_op(OP_REM, 32'hFFFF_FFFE, 32'd7, 32'd1, 33, "rem_7_m2");
      run_op(OP_DIV, 32'hFFFF_FFFE, 32'd7, 32'hFFFF_FFFD, 33, "div_7_m2");
   endtask

   task automatic test_div_zero();
      run_op(OP_DIVU, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1, "divu_by0");
      run_op(OP_REMU, 32'd0, 32'h1234_5678, 32'h1234_5678, 1, "remu_by0");
      run_op(OP_DIV, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1, "div_by0");
      run_op(OP_REM, 32'd0, 32'h8765_4321, 32'h8765_4321, 1, "rem_by0");
   endtask

   task automatic test_overflow();
      run_op(OP_DIV, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 1, "div_ovf");
      run_op(OP_REM, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1, "rem_ovf");
      // Same operands unsigned are an ordinary division
      run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, "divu_no_ovf");
   endtask

   task automatic test_backpressure();
      logic [31:0] exp;
      int lat;
      exp = 32'd100;
      issue(OP_DIVU, 32'd10, 32'd1000);
      lat = 1;
      while (!bus.valid_o && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      n_cmp++;
      if (lat !== 33) begin
         n_err++;
         $display("FAIL bp latency: got %0d expected 33", lat);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (bus.valid_o !== 1'b1 || bus.result_o !== exp || bus.ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL bp hold %0d: valid_o=%b result_o=%h ready_o=%b expected 1/%h/0",
                     i, bus.valid_o, bus.result_o, bus.ready_o, exp);
         end
      end
      bus.ready_i = 1'b1;
      @(posedge clk); #1;
      bus.ready_i = 1'b0;
      n_cmp++;
      if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL bp release: ready_o=%b valid_o=%b expected 1/0",
                  bus.ready_o, bus.valid_o);
      end
   endtask

   task automatic test_no_accept();
      // valid with kill, then valid without div_en: neither is accepted
      @(posedge clk); #1;
      bus.div_operator_i = OP_DIVU;
      bus.op_a_i         = 32'd0;
      bus.op_b_i         = 32'd5;
      bus.valid_i        = 1'b1;
      bus.div_en_i       = 1'b1;
      bus.kill_i         = 1'b1;
      @(posedge clk); #1;
      bus.kill_i         = 1'b0;
      bus.div_en_i       = 1'b0;
      n_cmp++;
      if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL valid_with_kill: ready_o=%b valid_o=%b expected 1/0",
                  bus.ready_o, bus.valid_o);
      end
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
      n_cmp++;
      if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL valid_without_en: ready_o=%b valid_o=%b expected 1/0",
                  bus.ready_o, bus.valid_o);
      end
   endtask

   task automatic test_kill();
      logic seen;
      issue(OP_DIVU, 32'd7, 32'd100);
      repeat (9) begin
         @(posedge clk); #1;
      end
      bus.kill_i = 1'b1;
      @(posedge clk); #1;
      bus.kill_i = 1'b0;
      n_cmp++;
      if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL kill_mid: ready_o=%b valid_o=%b expected 1/0",
                  bus.ready_o, bus.valid_o);
      end
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bus.valid_o) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_err++;
         $display("FAIL kill_no_valid: valid_o seen=%b expected 0", seen);
      end
      run_op(OP_DIV, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33, "div_m1_m1");

      // Kill in FINISH drops valid_o even with ready_i low
      issue(OP_DIVU, 32'd0, 32'd9);
      bus.kill_i = 1'b1;
      @(posedge clk); #1;
      bus.kill_i = 1'b0;
      n_cmp++;
      if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL kill_finish: valid_o=%b ready_o=%b expected 0/1",
                  bus.valid_o, bus.ready_o);
      end
   endtask

   task automatic test_reset_mid();
      issue(OP_DIVU, 32'd3, 32'd1000);
      repeat (19) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (bus.valid_o !== 1'b0 || bus.result_o !== 32'd0 || bus.ready_o !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid: valid_o=%b result_o=%h ready_o=%b expected 0/0/0",
                  bus.valid_o, bus.result_o, bus.ready_o);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid release: ready_o=%b valid_o=%b expected 1/0",
                  bus.ready_o, bus.valid_o);
      end
      run_op(OP_REMU, 32'd3, 32'd1000, 32'd1, 33, "remu_after_reset");
   endtask

   initial begin
      n_cmp              = 0;
      n_err              = 0;
      rst                = 1'b1;
      bus.div_en_i       = 1'b0;
      bus.div_operator_i = OP_DIV;
      bus.op_a_i         = 32'd0;
      bus.op_b_i         = 32'd0;
      bus.valid_i        = 1'b0;
      bus.kill_i         = 1'b0;
      bus.ready_i        = 1'b0;

      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_overflow();
      test_backpressure();
      test_no_accept();
      test_kill();
      test_reset_mid();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
